data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Parametrised successor of the single-cycle core's word-only data memory.
- Adds full RV32I sub-word load/store support (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension.
- Adds alignment/illegal-access error flagging, a registered read port with a valid/ready request handshake, and a sequential clear engine that zeroes memory after reset.
- Targets the multicycle/pipelined core; sits between the LSU address/data path and writeback.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..4096.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.
- CLEAR_ON_RESET, 1, 1 = sweep memory to zero after reset; 0 = skip the sweep, contents undefined after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  1  request present this cycle.
- REQ_READY  out  1  block accepts a request this cycle.
- WE  in  1  1 = store, 0 = load; sampled on accept.
- FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- A  in  32  byte address.
- WD  in  32  store data; low byte/half used for SB/SH.
- RD  out  32  registered load result, extended per FUNCT3.
- RD_VALID  out  1  one-cycle pulse: RD holds the result of a load accepted the previous cycle.
- ERR  out  1  one-cycle pulse: the access accepted the previous cycle was misaligned or illegal.
- BUSY  out  1  clear sweep in progress.

Behaviour:
- Accept condition: REQ_VALID && REQ_READY. REQ_READY = (state == IDLE) && !RST.
- Reset (RST high at a clock edge):
  - RD=0, RD_VALID=0, ERR=0.
  - state=CLEAR and clr_ptr=0 when CLEAR_ON_RESET=1; otherwise state=IDLE.
  - Reset asserted mid-sweep or mid-access aborts it; a pending RD_VALID/ERR is suppressed; the sweep restarts from 0.
- States:
  - CLEAR: each cycle write 0 to word clr_ptr, then clr_ptr++. After writing DEPTH_WORDS-1, go to IDLE the next cycle. Sweep lasts exactly DEPTH_WORDS cycles. BUSY=1, REQ_READY=0 throughout; requests are ignored, not queued.
  - IDLE: BUSY=0, one request accepted per cycle. No other states.
- Addressing:
  - Word index = A[IDX_W+1:2], lane = A[1:0].
  - Upper address bits are ignored, so the address wraps modulo 4*DEPTH_WORDS.
- Legality checks, evaluated on accept:
  - Illegal FUNCT3: 011, 110, 111 for loads; any value other than 000/001/010 for stores.
  - Misaligned: H/HU with A[0]=1; W with A[1:0]≠00.
  - Illegal or misaligned access: no memory write; RD forced to 0; ERR=1 next cycle; for a load, RD_VALID=1 alongside ERR.
- Store, byte enables BE[3:0] (lane k = bits 8k+7:8k):
  - SB: BE = 0001 << A[1:0]; WD[7:0] is replicated to the enabled lane.
  - SH: BE = 0011 << A[1:0]; WD[15:0] goes to lanes 1:0 or 3:2.
  - SW: BE = 1111.
  - Unenabled lanes are unchanged.
  - Writes commit at the accept edge. RD_VALID stays 0; RD holds its previous value.
- Load:
  - The word is read at the accept edge. The lane is selected by A[1:0] and extended: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - The result is registered into RD; RD_VALID=1 for exactly one cycle (latency 1).
  - RD holds its value until the next load result or reset.
- Ordering:
  - A store at cycle N followed by a load of the same word at N+1 returns the post-store data.
  - Back-to-back loads give RD_VALID high on consecutive cycles.
- Power-on with CLEAR_ON_RESET=1: reads issued after BUSY falls return 0 for every unwritten address.

Test Plan:
- Reset then sweep, DEPTH_WORDS=16: RST high 1 cycle → BUSY=1 and REQ_READY=0 for exactly 16 cycles; then a LW of 0x3C gives RD=0x00000000 with RD_VALID one cycle after accept.
- Store 0xDEADBEEF by SW to 0x08; SB 0x5A to 0x09; LW 0x08 → RD=0xDEAD5AEF. LB 0x0B → RD=0xFFFFFFDE. LBU 0x0B → RD=0x000000DE. LH 0x0A → RD=0xFFFFDEAD. LHU 0x0A → RD=0x0000DEAD.
- Misaligned: SW 0x11223344 to 0x06 → ERR pulse, word 1 unchanged (LW 0x04 returns its prior value). LH at 0x05 → RD=0, RD_VALID=1, ERR=1.
- Illegal FUNCT3=011 load → ERR=1, RD=0. Wrap: SW 0xA5A5A5A5 to 0x40 with DEPTH_WORDS=16, then LW 0x00 → RD=0xA5A5A5A5.
- Back-to-back: SW 0x12345678 to 0x20 at cycle N, LW 0x20 at N+1 → RD=0x12345678 at N+2.
- RST asserted on sweep cycle 5 → sweep restarts at clr_ptr=0, BUSY stays high a further 16 cycles. RST in the cycle after a load accept → RD_VALID stays 0 and RD=0.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Data memory with RV32I sub-word load/store, alignment/illegal-access
// error flagging, registered load port with valid/ready request handshake
// and a sequential clear sweep that zeroes the array after reset.
module data_memory_lsu #(
    parameter int DEPTH_WORDS    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        RD_VALID,
    output logic        ERR,
    output logic        BUSY
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [IDX_W-1:0]   w_clr_ptr_next;

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        r_rd;
    logic               r_rd_valid;
    logic               r_err;

    logic               w_accept;
    logic [IDX_W-1:0]   w_idx;
    logic [1:0]         w_lane;
    logic               w_f3_legal;
    logic               w_misalign;
    logic               w_acc_err;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [31:0]        w_load_ext;
    logic               w_unused_addr;

    assign w_idx         = A[IDX_W+1:2];
    assign w_lane        = A[1:0];
    assign w_unused_addr = ^A[31:IDX_W+2];
    assign w_accept      = REQ_VALID && REQ_READY;

    // State register and sweep pointer; reset (re)starts the sweep from word 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // Next-state logic: sweep ends after the last word has been written.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        BUSY           = 1'b0;
        REQ_READY      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                BUSY           = 1'b1;
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                REQ_READY = !RST;
            end
        endcase
    end

    // Legality: funct3 encoding check plus natural alignment for H/W.
    always_comb begin
        w_f3_legal = 1'b0;
        w_misalign = 1'b0;
        if (WE) begin
            w_f3_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010);
        end else begin
            w_f3_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                         (FUNCT3 == 3'b100) || (FUNCT3 == 3'b101);
        end
        if (FUNCT3[1:0] == 2'b01) begin
            w_misalign = A[0];
        end else if (FUNCT3[1:0] == 2'b10) begin
            w_misalign = (A[1:0] != 2'b00);
        end
        w_acc_err = !w_f3_legal || w_misalign;
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WD;
        case (FUNCT3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{WD[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_lane;
                w_wdata = {2{WD[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = WD;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = WD;
            end
        endcase
    end

    // Load lane select and sign/zero extension of the addressed word.
    always_comb begin
        w_word     = r_mem[w_idx];
        w_shift    = w_word >> {w_lane, 3'b000};
        w_load_ext = w_word;
        case (FUNCT3[1:0])
            2'b00:   w_load_ext = {{24{!FUNCT3[2] && w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load_ext = {{16{!FUNCT3[2] && w_shift[15]}}, w_shift[15:0]};
            default: w_load_ext = w_word;
        endcase
    end

    // Memory array: clear sweep writes take the port while BUSY, otherwise
    // accepted legal stores write the enabled byte lanes.
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == S_CLEAR)) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_accept && WE && !w_acc_err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered response: one-cycle RD_VALID/ERR pulses, RD held between loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_accept && !WE;
            r_err      <= w_accept && w_acc_err;
            if (w_accept && w_acc_err) begin
                r_rd <= '0;
            end else if (w_accept && !WE) begin
                r_rd <= w_load_ext;
            end
        end
    end

    assign RD       = r_rd;
    assign RD_VALID = r_rd_valid;
    assign ERR      = r_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu (DEPTH_WORDS=16): byte-addressed
// reference model, per-cycle compare on the falling edge, directed literal
// checks from the test plan and a randomized request phase.
module tb_data_memory_lsu;

    localparam int DW    = 16;
    localparam int BYTES = 4 * DW;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        WE;
    logic [2:0]  FUNCT3;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        RD_VALID;
    logic        ERR;
    logic        BUSY;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [7:0]  m_mem [BYTES];
    logic [31:0] m_rd;
    logic        m_rdv;
    logic        m_err;
    int          m_clr;
    bit          m_started = 1'b0;

    data_memory_lsu #(
        .DEPTH_WORDS   (DW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .WE       (WE),
        .FUNCT3   (FUNCT3),
        .A        (A),
        .WD       (WD),
        .RD       (RD),
        .RD_VALID (RD_VALID),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of the reference model: byte-addressed memory, size = 1<<funct3[1:0].
    task automatic model_step();
        int unsigned nb;
        int unsigned a;
        bit          legal;
        logic [31:0] val;
        if (RST) begin
            m_rd      = '0;
            m_rdv     = 1'b0;
            m_err     = 1'b0;
            m_clr     = DW;
            m_started = 1'b1;
        end else if (m_started) begin
            m_rdv = 1'b0;
            m_err = 1'b0;
            if (m_clr > 0) begin
                m_clr--;
                if (m_clr == 0) begin
                    for (int i = 0; i < BYTES; i++) m_mem[i] = 8'h00;
                end
            end else if (REQ_VALID) begin
                nb = 1 << FUNCT3[1:0];
                a  = A % BYTES;
                if (WE) legal = (FUNCT3 <= 3'd2);
                else    legal = (FUNCT3 <= 3'd2) || (FUNCT3 == 3'd4) || (FUNCT3 == 3'd5);
                if (!legal || (a % nb) != 0) begin
                    m_err = 1'b1;
                    m_rd  = '0;
                    m_rdv = !WE;
                end else if (WE) begin
                    for (int unsigned i = 0; i < nb; i++) m_mem[a+i] = 8'((WD >> (8*i)) & 32'hFF);
                end else begin
                    val = '0;
                    for (int unsigned i = 0; i < nb; i++) val = val | (32'(m_mem[a+i]) << (8*i));
                    if (!FUNCT3[2] && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
                    m_rd  = val;
                    m_rdv = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (m_started) begin
                chk("req_ready", 32'(REQ_READY), 32'((m_clr == 0) && !RST));
                chk("busy",      32'(BUSY),      32'(m_clr != 0));
                chk("rd_valid",  32'(RD_VALID),  32'(m_rdv));
                chk("err",       32'(ERR),       32'(m_err));
                chk("rd",        RD,             m_rd);
            end
        end
    end

    // Drive one request for one clock; returns #1 after the accept edge.
    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        REQ_VALID = 1'b1;
        WE        = we;
        FUNCT3    = f3;
        A         = a;
        WD        = wd;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic lit_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_rd, input logic exp_err);
        req(1'b0, f3, a, 32'h0);
        chk({nm, "_rd"},       RD,             exp_rd);
        chk({nm, "_model"},    m_rd,           exp_rd);
        chk({nm, "_rd_valid"}, 32'(RD_VALID),  32'd1);
        chk({nm, "_err"},      32'(ERR),       32'(exp_err));
    endtask

    task automatic lit_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_err);
        req(1'b1, f3, a, wd);
        chk({nm, "_err"},      32'(ERR),      32'(exp_err));
        chk({nm, "_rd_valid"}, 32'(RD_VALID), 32'd0);
    endtask

    // Count falling edges with BUSY high and REQ_READY low (bounded).
    task automatic busy_count(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (BUSY && !REQ_READY) n++;
            else break;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int          n;
        logic [31:0] ra;
        logic [2:0]  rf;

        RST       = 1'b1;
        REQ_VALID = 1'b0;
        WE        = 1'b0;
        FUNCT3    = 3'b000;
        A         = '0;
        WD        = '0;
        @(posedge CLK);
        #1;
        chk("reset_rd",       RD,            32'h0);
        chk("reset_rd_valid", 32'(RD_VALID), 32'd0);
        chk("reset_err",      32'(ERR),      32'd0);
        RST = 1'b0;
        busy_count(n);
        chk("sweep_len", 32'(n), 32'd16);

        lit_load("lw_3c_clear", 3'b010, 32'h3C, 32'h0000_0000, 1'b0);

        lit_store("sw_08", 3'b010, 32'h08, 32'hDEAD_BEEF, 1'b0);
        lit_store("sb_09", 3'b000, 32'h09, 32'h0000_005A, 1'b0);
        lit_load("lw_08",  3'b010, 32'h08, 32'hDEAD_5AEF, 1'b0);
        lit_load("lb_0b",  3'b000, 32'h0B, 32'hFFFF_FFDE, 1'b0);
        lit_load("lbu_0b", 3'b100, 32'h0B, 32'h0000_00DE, 1'b0);
        lit_load("lh_0a",  3'b001, 32'h0A, 32'hFFFF_DEAD, 1'b0);
        lit_load("lhu_0a", 3'b101, 32'h0A, 32'h0000_DEAD, 1'b0);

        lit_store("sw_04", 3'b010, 32'h04, 32'h0BAD_F00D, 1'b0);
        lit_store("sw_06_mis", 3'b010, 32'h06, 32'h1122_3344, 1'b1);
        chk("sw_06_mis_rd", RD, 32'h0);
        lit_load("lw_04_kept",  3'b010, 32'h04, 32'h0BAD_F00D, 1'b0);
        lit_load("lh_05_mis",   3'b001, 32'h05, 32'h0, 1'b1);
        lit_load("lw_04_again", 3'b010, 32'h04, 32'h0BAD_F00D, 1'b0);
        lit_load("ld_f3_011",   3'b011, 32'h08, 32'h0, 1'b1);
        lit_store("sh_f3_101",  3'b101, 32'h08, 32'h0000_FFFF, 1'b1);
        lit_load("lw_08_kept",  3'b010, 32'h08, 32'hDEAD_5AEF, 1'b0);

        lit_store("sw_40_wrap", 3'b010, 32'h40, 32'hA5A5_A5A5, 1'b0);
        lit_load("lw_00_wrap",  3'b010, 32'h00, 32'hA5A5_A5A5, 1'b0);
        lit_store("sh_0e",      3'b001, 32'h0E, 32'h0000_8001, 1'b0);
        lit_load("lw_0c",       3'b010, 32'h0C, 32'h8001_0000, 1'b0);

        lit_store("sw_20", 3'b010, 32'h20, 32'h1234_5678, 1'b0);
        lit_load("lw_20_b2b", 3'b010, 32'h20, 32'h1234_5678, 1'b0);
        req(1'b0, 3'b010, 32'h20, 32'h0);
        req(1'b0, 3'b000, 32'h21, 32'h0);
        chk("b2b_second_valid", 32'(RD_VALID), 32'd1);
        chk("b2b_second_rd",    RD,            32'h0000_0056);

        // randomized phase, checked by the per-cycle compare process
        for (int i = 0; i < 800; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rf[1:0] == 2'b01) ra[0] = 1'b0;
                if (rf[1:0] == 2'b10) ra[1:0] = 2'b00;
            end
            RST       = ($urandom_range(0, 299) == 0);
            REQ_VALID = ($urandom_range(0, 3) != 0);
            WE        = ($urandom_range(0, 2) == 0);
            FUNCT3    = rf;
            A         = ra;
            WD        = $urandom;
            @(posedge CLK);
            #1;
        end
        REQ_VALID = 1'b0;
        RST       = 1'b0;

        // reset during the sweep restarts it from word 0
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        busy_count(n);
        chk("sweep_restart_len", 32'(n), 32'd16);
        lit_load("lw_08_after_clear", 3'b010, 32'h08, 32'h0, 1'b0);

        // reset in the cycle after a load accept clears RD
        lit_store("sw_10", 3'b010, 32'h10, 32'hCAFE_F00D, 1'b0);
        req(1'b0, 3'b010, 32'h10, 32'h0);
        RST = 1'b1;
        chk("pre_reset_rd", RD, 32'hCAFE_F00D);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("post_reset_rd",       RD,            32'h0);
        chk("post_reset_rd_valid", 32'(RD_VALID), 32'd0);
        busy_count(n);
        chk("sweep_len_final", 32'(n), 32'd16);

        repeat (2) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
